unit_prop_ctrl: RTL and testbench
=================================

UNIT_PROP_CTRL -- requirements
Module: unit_prop_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  begin propagation on in_formula; sampled only in IDLE.
REQ-004 SHALL have port: in_formula  in  formula (234)  formula to simplify.
REQ-005 SHALL have port: pl_find  out  1  request to propagateliteral; held high until pl_ended.
REQ-006 SHALL have port: pl_lit  out  lit (4)  literal being propagated.
REQ-007 SHALL have port: pl_formula  out  formula  working formula presented to propagateliteral.
REQ-008 SHALL have ports: pl_ended, pl_empty_clause, pl_empty_formula  in  1 each  propagateliteral status.
REQ-009 SHALL have port: pl_out_formula  in  formula  reduced formula from propagateliteral.
REQ-010 SHALL have ports: busy  out  1;  done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: result  out  2  00 none, 01 SAT, 10 UNSAT, 11 undetermined (no unit clause left).
REQ-012 SHALL have ports: out_formula  out  formula;  assign_mask, assign_val  out  8 each (bit v = var v);  prop_count  out  4.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, WAIT, DONE.
REQ-014 IDLE: start=1 -> load in_formula into working register, clear clause index, go SCAN next cycle; busy=0.
REQ-015 SCAN: examines one clause per cycle, index 0..formula count-1, busy=1.
REQ-016 SCAN, working formula count == 0 -> DONE, result 01, without examining clauses.
REQ-017 SCAN, clause count == 0 at index < formula count -> DONE, result 10.
REQ-018 SCAN, clause count == 1 -> unit literal = the slot with var != 0; register pl_lit, assert pl_find next cycle, go WAIT.
REQ-019 SCAN reaching index == formula count with no unit -> DONE, result 11.
REQ-020 WAIT: pl_find, pl_lit, pl_formula stable until the cycle pl_ended=1; pl_find deasserts the following cycle.
REQ-021 WAIT, pl_ended=1: capture pl_out_formula, set assign_mask[var]=1, assign_val[var]=polarity, prop_count saturating +1 at 15.
REQ-022 Same edge: pl_empty_clause -> DONE result 10; else pl_empty_formula -> DONE result 01; else SCAN from index 0.
REQ-023 pl_empty_clause and pl_empty_formula both high -> UNSAT (10) takes precedence.
REQ-024 Unit literal on already-assigned var is still issued; assign_val overwritten; no extra check.
REQ-025 DONE: done=1 for exactly one cycle, busy=1, then IDLE; result, out_formula, assign_*, prop_count held until next accepted start.
REQ-026 start while busy SHALL be ignored; pl_* status inputs outside WAIT SHALL be ignored.
REQ-027 out_formula SHALL always equal the working formula register.
REQ-028 Latency: start -> first pl_find = 2 + (index of first unit clause) cycles.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, pl_find=0, done=0, busy=0, result=00, pl_lit=zero_lit, working formula, pl_formula/out_formula all-zero, assign_mask=0, assign_val=0, prop_count=0, index=0.
REQ-030 Reset mid-WAIT SHALL abandon the request; a late pl_ended after reset SHALL be ignored.

Configuration
REQ-031 Macro UNIT_PROP_TIMEOUT_EN defined: 8-bit watchdog cleared on WAIT entry, +1 per WAIT cycle; at 255 without pl_ended -> drop pl_find, DONE, result 11, timeout output (1 bit, reset 0) set until next start.
REQ-032 Macro undefined: no watchdog, no timeout port; WAIT waits indefinitely.

Verification
REQ-033 Formula count 0, start -> done 2 cycles later, result 01, pl_find never asserted.
REQ-034 Clauses {(x1 v x2),(x3)}, count 2, start -> pl_lit={3'b011,1}, stub ends with empty_formula -> result 01, assign_mask=8'h08, assign_val=8'h08, prop_count=1.
REQ-035 Ten-clause formula, stub returns empty_clause on 2nd propagation -> result 10, prop_count=2, done one cycle.
REQ-036 Formula of only 2-literal clauses -> result 11, prop_count=0, done after count+1 SCAN cycles.
REQ-037 reset pulsed in WAIT with pl_find=1 -> pl_find=0, all outputs at reset values; later pl_ended ignored.
REQ-038 UNIT_PROP_TIMEOUT_EN, stub never asserts pl_ended -> done 255 cycles after WAIT entry, result 11, timeout=1.

Source files
------------

// File: rtl/unit_prop_ctrl.sv
// Unit-propagation controller: scans the working formula for a unit clause, hands it to
// propagateliteral, folds the reduced formula back in. Optional watchdog: UNIT_PROP_TIMEOUT_EN.
module unit_prop_ctrl (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [233:0] in_formula,
  output logic         pl_find,
  output logic [3:0]   pl_lit,
  output logic [233:0] pl_formula,
  input  logic         pl_ended,
  input  logic         pl_empty_clause,
  input  logic         pl_empty_formula,
  input  logic [233:0] pl_out_formula,
  output logic         busy,
  output logic         done,
  output logic [1:0]   result,
  output logic [233:0] out_formula,
  output logic [7:0]   assign_mask,
  output logic [7:0]   assign_val,
  output logic [3:0]   prop_count,
`ifdef UNIT_PROP_TIMEOUT_EN
  output logic         timeout,
`endif
  output logic [1:0]   state_dbg
);

  // Formula: [233:230] clause count, clause i at [i*23 +: 23].
  // Clause: [22:20] literal count, literal j at [j*4 +: 4]. Literal: {var[2:0], polarity}.
  localparam int NCL  = 10;
  localparam int CLW  = 23;
  localparam int NLIT = 5;
  localparam int LW   = 4;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_SAT   = 2'b01;
  localparam logic [1:0] RES_UNSAT = 2'b10;
  localparam logic [1:0] RES_UNDET = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t         state, state_nxt;
  logic [233:0]   work;
  logic [3:0]     idx;
  logic [3:0]     f_cnt;
  logic [CLW-1:0] clause_tbl [0:15];
  logic [CLW-1:0] cur_clause;
  logic [2:0]     cl_cnt;
  logic [LW-1:0]  unit_lit;
  logic           go_wait, finish, accept;
  logic [1:0]     fin_code;
`ifdef UNIT_PROP_TIMEOUT_EN
  logic [7:0]     wd;
  logic           tmo;
`endif

  assign f_cnt = work[233:230];

  // Indices past the physical clause slots read as empty clauses.
  always_comb begin
    for (int i = 0; i < 16; i++) clause_tbl[i] = '0;
    for (int i = 0; i < NCL; i++) clause_tbl[i] = work[i*CLW +: CLW];
  end

  assign cur_clause = clause_tbl[idx];
  assign cl_cnt     = cur_clause[22:20];

  // Lowest slot holding a non-zero variable is the unit literal.
  always_comb begin
    unit_lit = '0;
    for (int j = NLIT - 1; j >= 0; j--) begin
      if (cur_clause[j*LW+1 +: 3] != 3'd0) unit_lit = cur_clause[j*LW +: LW];
    end
  end

  // Handshake: pl_find rises with pl_lit/pl_formula valid and holds them until the cycle
  // pl_ended=1 is sampled in WAIT; that edge consumes pl_out_formula and the status flags.
  always_comb begin
    state_nxt = state;
    go_wait   = 1'b0;
    finish    = 1'b0;
    fin_code  = RES_NONE;
    accept    = 1'b0;
`ifdef UNIT_PROP_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (f_cnt == 4'd0) begin
          finish = 1'b1; fin_code = RES_SAT;
        end else if (idx == f_cnt) begin
          finish = 1'b1; fin_code = RES_UNDET;
        end else if (cl_cnt == 3'd0) begin
          finish = 1'b1; fin_code = RES_UNSAT;
        end else if (cl_cnt == 3'd1) begin
          go_wait = 1'b1; state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (pl_ended) begin
          accept = 1'b1;
          if (pl_empty_clause) begin
            finish = 1'b1; fin_code = RES_UNSAT;
          end else if (pl_empty_formula) begin
            finish = 1'b1; fin_code = RES_SAT;
          end else begin
            state_nxt = SCAN;
          end
        end
`ifdef UNIT_PROP_TIMEOUT_EN
        // Count 255 WAIT cycles (0..254) before giving up.
        else if (wd == 8'd254) begin
          tmo = 1'b1; finish = 1'b1; fin_code = RES_UNDET;
        end
`endif
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (finish) state_nxt = DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work        <= '0;
      idx         <= '0;
      pl_find     <= 1'b0;
      pl_lit      <= '0;
      result      <= RES_NONE;
      assign_mask <= '0;
      assign_val  <= '0;
      prop_count  <= '0;
`ifdef UNIT_PROP_TIMEOUT_EN
      wd          <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        work        <= in_formula;
        idx         <= '0;
        result      <= RES_NONE;
        assign_mask <= '0;
        assign_val  <= '0;
        prop_count  <= '0;
`ifdef UNIT_PROP_TIMEOUT_EN
        timeout     <= 1'b0;
`endif
      end
      if (state == SCAN && !finish && !go_wait) idx <= idx + 4'd1;
      if (go_wait) begin
        pl_lit  <= unit_lit;
        pl_find <= 1'b1;
`ifdef UNIT_PROP_TIMEOUT_EN
        wd      <= '0;
`endif
      end
      if (accept) begin
        pl_find                 <= 1'b0;
        work                    <= pl_out_formula;
        assign_mask[pl_lit[3:1]] <= 1'b1;
        assign_val[pl_lit[3:1]]  <= pl_lit[0];
        if (prop_count != 4'd15) prop_count <= prop_count + 4'd1;
        idx                     <= '0;
      end
      if (finish) result <= fin_code;
`ifdef UNIT_PROP_TIMEOUT_EN
      if (state == WAIT && !accept) wd <= wd + 8'd1;
      if (tmo) begin
        pl_find <= 1'b0;
        timeout <= 1'b1;
      end
`endif
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign pl_formula  = work;
  assign out_formula = work;
  assign state_dbg   = state;

endmodule

// File: tb/tb_unit_prop_ctrl.sv
// Bench for unit_prop_ctrl: propagateliteral stub, clause-level reference model,
// queue scoreboard with a negedge monitor. Define UNIT_PROP_TIMEOUT_EN to cover the watchdog.
module tb_unit_prop_ctrl;
  localparam int FW = 234;
  typedef logic [FW-1:0] form_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  form_t       in_formula = '0;
  logic        pl_find;
  logic [3:0]  pl_lit;
  form_t       pl_formula;
  logic        pl_ended = 1'b0;
  logic        pl_empty_clause = 1'b0;
  logic        pl_empty_formula = 1'b0;
  form_t       pl_out_formula = '0;
  logic        busy, done;
  logic [1:0]  result;
  form_t       out_formula;
  logic [7:0]  assign_mask, assign_val;
  logic [3:0]  prop_count;
  logic [1:0]  state_dbg;
`ifdef UNIT_PROP_TIMEOUT_EN
  logic        timeout;
`endif

  unit_prop_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .in_formula(in_formula),
    .pl_find(pl_find), .pl_lit(pl_lit), .pl_formula(pl_formula),
    .pl_ended(pl_ended), .pl_empty_clause(pl_empty_clause),
    .pl_empty_formula(pl_empty_formula), .pl_out_formula(pl_out_formula),
    .busy(busy), .done(done), .result(result), .out_formula(out_formula),
    .assign_mask(assign_mask), .assign_val(assign_val), .prop_count(prop_count),
`ifdef UNIT_PROP_TIMEOUT_EN
    .timeout(timeout),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_seen = 0;
  bit chk_en = 0;
  bit stub_en = 0;
  int stub_mode = 0;

  // lit entry: {expected latency or 255, literal}; final entry: {res, mask, val, count, formula, latency}
  logic [11:0]  lit_q[$];
  logic [263:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    errors++;
    checks++;
    $display("FAIL %s actual=no response required=response within bound", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // ---------------- formula helpers (signed literal view: +v / -v, 0 = empty) ----------------
  function automatic int lit_val(input logic [3:0] l);
    if (l[3:1] == 3'd0) return 0;
    return l[0] ? int'(l[3:1]) : -int'(l[3:1]);
  endfunction

  function automatic logic [3:0] enc_lit(input int l);
    int v;
    v = (l < 0) ? -l : l;
    return {v[2:0], (l > 0)};
  endfunction

  function automatic int fcount(input form_t f);
    return int'(f[233:230]);
  endfunction

  function automatic int ccount(input form_t f, input int i);
    return int'(f[i*23+20 +: 3]);
  endfunction

  function automatic int get_lit(input form_t f, input int i, input int j);
    return lit_val(f[i*23+j*4 +: 4]);
  endfunction

  function automatic form_t rand_form();
    form_t r;
    for (int i = 0; i < FW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic form_t put_clause(input form_t f, input int i, input int a, input int b, input int c);
    form_t o;
    int k;
    int ls[3];
    o = f; ls[0] = a; ls[1] = b; ls[2] = c; k = 0;
    o[i*23 +: 23] = '0;
    for (int j = 0; j < 3; j++) begin
      if (ls[j] != 0) begin
        o[i*23+k*4 +: 4] = enc_lit(ls[j]);
        k++;
      end
    end
    o[i*23+20 +: 3] = k[2:0];
    return o;
  endfunction

  // Literal propagation: drop satisfied clauses, strip the negated literal, compact the rest.
  function automatic form_t propagate(input form_t f, input int lit, output bit ec, output bit ef);
    form_t o;
    int n, k, l;
    bit sat;
    o = '0; n = 0; ec = 0;
    for (int i = 0; i < fcount(f) && i < 10; i++) begin
      sat = 0;
      for (int j = 0; j < 5; j++) if (get_lit(f, i, j) == lit) sat = 1;
      if (!sat) begin
        k = 0;
        for (int j = 0; j < 5; j++) begin
          l = get_lit(f, i, j);
          if (l != 0 && l != -lit) begin
            o[n*23+k*4 +: 4] = enc_lit(l);
            k++;
          end
        end
        o[n*23+20 +: 3] = k[2:0];
        if (k == 0) ec = 1;
        n++;
      end
    end
    o[233:230] = n[3:0];
    ef = (n == 0);
    return o;
  endfunction

  function automatic form_t gen_form();
    form_t f;
    logic [22:0] c;
    int n, k, p, r, v, slot;
    f = rand_form();
    n = $urandom_range(0, 10);
    for (int i = 0; i < n; i++) begin
      p = $urandom_range(0, 99);
      k = (p < 4) ? 0 : (p < 40) ? 1 : (p < 75) ? 2 : (p < 92) ? 3 : $urandom_range(4, 5);
      r = $urandom_range(0, 4);
      c = '0;
      for (int j = 0; j < k; j++) begin
        slot = (j + r) % 5;
        v = $urandom_range(1, 7);
        c[slot*4 +: 4] = {v[2:0], 1'($urandom_range(0, 1))};
      end
      c[22:20] = k[2:0];
      f[i*23 +: 23] = c;
    end
    f[233:230] = n[3:0];
    return f;
  endfunction

  // ---------------- reference model ----------------
  // mode 0: genuine propagation; 1: propagator reports empty formula; 2: reports both flags.
  task automatic model_run(input form_t f, input int mode);
    form_t w;
    int props, res, dl, u, e, n, l;
    bit ec, ef;
    logic [7:0] mask, val;
    logic [3:0] ul;
    w = f; props = 0; mask = '0; val = '0; dl = 255; res = 0;
    forever begin
      n = fcount(w);
      if (n == 0) begin
        res = 1;
        if (props == 0) dl = 2;
        break;
      end
      u = -1; e = -1;
      for (int i = 0; i < n; i++) begin
        if (ccount(w, i) == 0) begin e = i; break; end
        if (ccount(w, i) == 1) begin u = i; break; end
      end
      if (e >= 0) begin
        res = 2;
        if (props == 0) dl = 2 + e;
        break;
      end
      if (u < 0) begin
        res = 3;
        if (props == 0) dl = n + 2;
        break;
      end
      l = 0;
      for (int j = 4; j >= 0; j--) if (get_lit(w, u, j) != 0) l = get_lit(w, u, j);
      ul = enc_lit(l);
      lit_q.push_back({(props == 0) ? 8'(2 + u) : 8'd255, ul});
      w = propagate(w, l, ec, ef);
      if (mode == 1) begin ec = 0; ef = 1; end
      else if (mode == 2) begin ec = 1; ef = 1; end
      if (props < 15) props++;
      mask[ul[3:1]] = 1'b1;
      val[ul[3:1]]  = ul[0];
      if (ec) begin res = 2; break; end
      if (ef) begin res = 1; break; end
    end
    exp_q.push_back({res[1:0], mask, val, 4'(props), w, 8'(dl)});
  endtask

  // ---------------- propagateliteral stub ----------------
  initial begin : stub
    int dly;
    bit act, ec, ef;
    form_t o;
    act = 0; dly = 0;
    forever begin
      @(posedge clock); #2;
      if (stub_en) begin
        if (pl_find) begin
          if (!act) begin act = 1; dly = $urandom_range(0, 3); end
          if (dly == 0) begin
            o = propagate(pl_formula, lit_val(pl_lit), ec, ef);
            if (stub_mode == 1) begin ec = 0; ef = 1; end
            else if (stub_mode == 2) begin ec = 1; ef = 1; end
            pl_out_formula   = o;
            pl_empty_clause  = ec;
            pl_empty_formula = ef;
            pl_ended         = 1'b1;
            act = 0;
          end else begin
            dly--;
            pl_ended         = 1'b0;
            pl_empty_clause  = 1'($urandom_range(0, 1));
            pl_empty_formula = 1'($urandom_range(0, 1));
          end
        end else begin
          act = 0;
          pl_ended         = ($urandom_range(0, 3) == 0);
          pl_empty_clause  = 1'($urandom_range(0, 1));
          pl_empty_formula = 1'($urandom_range(0, 1));
          pl_out_formula   = rand_form();
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit pf, pe, after;
    logic [3:0] held;
    logic [11:0] e;
    logic [263:0] x;
    pf = 0; pe = 0; after = 0; held = '0;
    forever begin
      @(negedge clock);
      if (!chk_en) begin
        pf = 0; pe = 0; after = 0;
      end else begin
        if (after) begin
          chk("done_one_cycle", done, 0);
          chk("idle_after_done", busy, 0);
          after = 0;
        end
        if (pl_find && !pf) begin
          if (lit_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pl_find actual=pl_find high required=no request");
          end else begin
            e = lit_q.pop_front();
            chk("pl_lit", pl_lit, e[3:0]);
            if (e[11:4] != 8'd255) chk("find_latency", cyc - start_cyc, e[11:4]);
          end
          held = pl_lit;
        end else if (pl_find && pf && !pe) begin
          chk("pl_lit_stable", pl_lit, held);
        end
        if (pe) chk("find_drop", pl_find, 0);
        pe = pl_find && pl_ended;
        pf = pl_find;
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=done high required=no run pending");
          end else begin
            x = exp_q.pop_front();
            chk("result", result, x[263:262]);
            chk("assign_mask", assign_mask, x[261:254]);
            chk("assign_val", assign_val, x[253:246]);
            chk("prop_count", prop_count, x[245:242]);
            chk("out_formula", out_formula, x[241:8]);
            if (x[7:0] != 8'd255) chk("done_latency", cyc - start_cyc, x[7:0]);
            chk("busy_in_done", busy, 1);
          end
          after = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_pl_find"}, pl_find, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_pl_lit"}, pl_lit, 0);
    chk({tag, "_out_formula"}, out_formula, 0);
    chk({tag, "_pl_formula"}, pl_formula, 0);
    chk({tag, "_assign_mask"}, assign_mask, 0);
    chk({tag, "_assign_val"}, assign_val, 0);
    chk({tag, "_prop_count"}, prop_count, 0);
    chk({tag, "_state"}, state_dbg, 0);
`ifdef UNIT_PROP_TIMEOUT_EN
    chk({tag, "_timeout"}, timeout, 0);
`endif
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic run_one(input form_t f, input int mode);
    int d0, t;
    model_run(f, mode);
    stub_mode = mode;
    d0 = done_seen;
    in_formula = f;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    t = 0;
    while (done_seen == d0 && t < 3000) begin
      if (busy && $urandom_range(0, 4) == 0) begin
        start = 1'b1;
        in_formula = rand_form();
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      t++;
    end
    start = 1'b0;
    if (done_seen == d0) abort("done_wait");
  endtask

  task automatic wait_cond_find(input int bound);
    int t;
    t = 0;
    while (!pl_find && t < bound) begin @(posedge clock); #1; t++; end
    if (!pl_find) abort("find_wait");
  endtask

  task automatic wait_cond_done(input int bound);
    int t;
    t = 0;
    while (!done && t < bound) begin @(posedge clock); #1; t++; end
    if (!done) abort("done_wait_direct");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    form_t f034, f035, f, g;
    int n;
    f034 = '0;
    f034 = put_clause(f034, 0, 1, 2, 0);
    f034 = put_clause(f034, 1, 3, 0, 0);
    f034[233:230] = 4'd2;

    f035 = '0;
    f035 = put_clause(f035, 0, 1, 4, 5);
    f035 = put_clause(f035, 1, 2, 0, 0);
    f035 = put_clause(f035, 2, -2, 3, 0);
    f035 = put_clause(f035, 3, -2, -3, 0);
    f035 = put_clause(f035, 4, 4, 5, 0);
    f035 = put_clause(f035, 5, 5, 6, 0);
    f035 = put_clause(f035, 6, 6, 7, 0);
    f035 = put_clause(f035, 7, -4, 7, 0);
    f035 = put_clause(f035, 8, 1, -6, 0);
    f035 = put_clause(f035, 9, 4, -7, 0);
    f035[233:230] = 4'd10;

    #1 reset = 1'b1;
    #1 check_reset("reset_async");
    repeat (3) @(posedge clock);
    #1;
    check_reset("reset_hold");
    reset = 1'b0;
    chk_en = 1; stub_en = 1;
    @(posedge clock); #1;

    // empty formula: SAT two cycles after start, no request
    f = rand_form(); f[233:230] = 4'd0;
    run_one(f, 0);
    // two clauses, unit x3, propagator reports empty formula
    run_one(f034, 1);
    // conflict on the second propagation
    run_one(f035, 0);
    // both flags: UNSAT wins
    run_one(f034, 2);
    // only two-literal clauses: undetermined
    for (int r = 0; r < 3; r++) begin
      f = rand_form();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) f = put_clause(f, i, $urandom_range(1, 7), -$urandom_range(1, 7), 0);
      f[233:230] = n[3:0];
      run_one(f, 0);
    end
    // random formulas
    for (int r = 0; r < 150; r++) run_one(gen_form(), ($urandom_range(0, 9) == 0) ? 2 : 0);

    // reset in WAIT abandons the request; a late pl_ended is ignored
    chk_en = 0; stub_en = 0;
    pl_ended = 1'b0; pl_empty_clause = 1'b0; pl_empty_formula = 1'b0;
    in_formula = f034; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_cond_find(20);
    @(posedge clock); #3;
    reset = 1'b1;
    #1 check_reset("reset_wait");
    @(posedge clock); #1;
    reset = 1'b0;
    g = rand_form();
    pl_out_formula = g; pl_ended = 1'b1; pl_empty_formula = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    pl_ended = 1'b0; pl_empty_formula = 1'b0;
    check_reset("late_ended");
    chk_en = 1; stub_en = 1;
    @(posedge clock); #1;
    run_one(f035, 0);

`ifdef UNIT_PROP_TIMEOUT_EN
    begin : watchdog_test
      int w, d;
      chk_en = 0; stub_en = 0;
      @(posedge clock); #1;
      pl_ended = 1'b0;
      in_formula = f034; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_cond_find(20);
      w = cyc;
      wait_cond_done(400);
      d = cyc;
      chk("timeout_latency", d - w, 255);
      chk("timeout_result", result, 2'b11);
      chk("timeout_flag", timeout, 1);
      chk("timeout_find_low", pl_find, 0);
      @(posedge clock); #1;
      f = rand_form(); f[233:230] = 4'd0;
      in_formula = f; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_cond_done(10);
      chk("timeout_cleared", timeout, 0);
      chk("timeout_next_result", result, 2'b01);
      @(posedge clock); #1;
      chk_en = 1; stub_en = 1;
    end
`endif

    chk("lit_q_drained", lit_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_bound
    #900000;
    errors++;
    $display("FAIL global_timeout actual=still running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
